// File: rtl/sha_padder.sv
// Byte-stream to SHA-256 padded 512-bit block builder (0x80 marker, zero fill, 64-bit length).
// Latency: block_valid rises the cycle after the beat that completes a block; follow-on blocks one cycle after the previous transfer.
// Backpressure: in_ready is low whenever a block is presented; block/block_last hold while block_ready is low.
module sha_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [511:0] block,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready
);

    typedef enum logic [1:0] {
        ABSORB     = 2'd0,
        FULL_EMIT  = 2'd1,
        OVF_EMIT   = 2'd2,
        FINAL_EMIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         ptr_q, ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [511:0]       buf_q, buf_d;
    logic               pend80_q, pend80_d;

    // Bytes used in the block after the current beat (64 means the block is full).
    logic [6:0]         used;
    // Message length in bits as it stands in the registered counter.
    logic [LEN_W-1:0]   len_bits_q;

    assign used       = {1'b0, ptr_q} + {6'd0, ~in_empty};
    assign len_bits_q = {len_q[LEN_W-4:0], 3'b000};

    // State, pointer, length counter and block buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ABSORB;
            ptr_q    <= 6'd0;
            len_q    <= '0;
            buf_q    <= '0;
            pend80_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            buf_q    <= buf_d;
            pend80_q <= pend80_d;
        end
    end

    // Next-state: absorb bytes, insert padding on the last beat, release blocks on transfer.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        buf_d    = buf_q;
        pend80_d = pend80_q;

        case (state_q)
            ABSORB: begin
                if (in_valid) begin
                    if (!in_empty) begin
                        // Byte k lives at [511-8k -: 8]; 63-k equals ~k for a 6-bit k.
                        buf_d[{~ptr_q, 3'b000} +: 8] = in_data;
                        ptr_d = ptr_q + 6'd1;
                        len_d = len_q + 1'b1;
                    end
                    if (in_last) begin
                        if (used == 7'd64) begin
                            // No room for the marker: it opens the next block.
                            state_d  = FULL_EMIT;
                            pend80_d = 1'b1;
                        end else begin
                            // Bytes past the data are already zero, so only the marker is written.
                            buf_d[{~used[5:0], 3'b000} +: 8] = 8'h80;
                            if (used <= 7'd55) begin
                                buf_d[63:0] = {len_d[LEN_W-4:0], 3'b000};
                                state_d     = FINAL_EMIT;
                            end else begin
                                state_d = OVF_EMIT;
                            end
                        end
                    end else if (used == 7'd64) begin
                        state_d  = FULL_EMIT;
                        pend80_d = 1'b0;
                    end
                end
            end
            FULL_EMIT: begin
                if (block_ready) begin
                    buf_d = '0;
                    ptr_d = 6'd0;
                    if (pend80_q) begin
                        buf_d[511:504] = 8'h80;
                        buf_d[63:0]    = len_bits_q;
                        state_d        = FINAL_EMIT;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end
            OVF_EMIT: begin
                if (block_ready) begin
                    buf_d       = '0;
                    buf_d[63:0] = len_bits_q;
                    state_d     = FINAL_EMIT;
                end
            end
            FINAL_EMIT: begin
                if (block_ready) begin
                    ptr_d    = 6'd0;
                    len_d    = '0;
                    buf_d    = '0;
                    pend80_d = 1'b0;
                    state_d  = ABSORB;
                end
            end
            default: state_d = ABSORB;
        endcase
    end

    assign in_ready    = (state_q == ABSORB);
    assign block_valid = (state_q != ABSORB);
    assign block_last  = (state_q == FINAL_EMIT);
    assign block       = buf_q;

endmodule
